alu: RTL and testbench

- 32-bit integer arithmetic/logic unit for the core's execute stage.
- Combines two source operands (rs1, rs2) under a 4-bit opcode from the control unit.
- Registers the result on the rising clock edge.
- Purely a datapath element: no handshake, one new operation may be issued every cycle.

---
 rtl/alu.sv | 76 +++++++
 tb/tb_alu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 32-bit integer ALU for the execute stage, one operation per cycle.
// Optional multiply on opcode 1010 when ALU_MUL_EN is defined.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [3:0]       ALUop,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result_next;
  logic             zero_next;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;

  assign shamt = rs2[SHW-1:0];

  // Reserved and unknown opcodes fall through to the zero default.
  always_comb begin
    result_next = '0;
    case (ALUop)
      OP_ADD:  result_next = rs1 + rs2;
      OP_SUB:  result_next = rs1 - rs2;
      OP_XOR:  result_next = rs1 ^ rs2;
      OP_OR:   result_next = rs1 | rs2;
      OP_AND:  result_next = rs1 & rs2;
      OP_SLL:  result_next = rs1 << shamt;
      OP_SRL:  result_next = rs1 >> shamt;
      OP_SRA:  result_next = $unsigned($signed(rs1) >>> shamt);
      OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
`ifdef ALU_MUL_EN
      OP_MUL:  result_next = rs1 * rs2;
`endif
      default: result_next = '0;
    endcase
  end

  // Flag derives from the value being loaded, so it always matches result.
  assign zero_next = (result_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else begin
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

  assign result = result_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [3:0]  ALUop;
  logic [31:0] result;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_result;
  logic        exp_zero;
  bit          exp_valid = 1'b0;

  always #5 clk = ~clk;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .rs1    (rs1),
    .rs2    (rs2),
    .ALUop  (ALUop),
    .result (result),
    .zero   (zero)
  );

  // Behavioural reference: returns {zero, result}.
  function automatic logic [32:0] model(input logic r, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] op);
    logic [31:0] v;
    int          sh;
    longint      sa;
    longint      sb;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = 32'h0;
    if (!r) begin
      case (op)
        4'd9:  v = a + b;
        4'd1:  v = a - b;
        4'd2:  v = a ^ b;
        4'd3:  v = a | b;
        4'd4:  v = a & b;
        4'd5:  v = a << sh;
        4'd13: v = a >> sh;
        4'd14: begin
          v = a >> sh;
          if (a[31] && sh > 0) v = v | ~(32'hFFFF_FFFF >> sh);
        end
        4'd6:  v = (sa < sb) ? 32'd1 : 32'd0;
        4'd7:  v = ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
        4'd10: v = 32'((longint'(a) * longint'(b)) & 64'hFFFF_FFFF);
`endif
        default: v = 32'h0;
      endcase
    end
    return {(v == 32'h0), v};
  endfunction

  // Model tracks what the DUT samples at each rising edge.
  always @(posedge clk) begin
    {exp_zero, exp_result} = model(rst, rs1, rs2, ALUop);
    exp_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (result !== exp_result || zero !== exp_zero) begin
        failures++;
        $display("FAIL model t=%0t result=%h zero=%b expected result=%h zero=%b",
                 $time, result, zero, exp_result, exp_zero);
      end else begin
        $display("txn t=%0t rst=%b op=%b result=%h zero=%b", $time, rst, ALUop, result, zero);
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    rst   = r;
    rs1   = a;
    rs2   = b;
    ALUop = op;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] er, input logic ez);
    checks++;
    if (result !== er || zero !== ez) begin
      failures++;
      $display("FAIL %s result=%h zero=%b required result=%h zero=%b",
               name, result, zero, er, ez);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; rs1 = 32'd12; rs2 = 32'd18; ALUop = 4'b1001;

    step(1'b1, 32'd12, 32'd18, 4'b1001);
    step(1'b1, 32'd12, 32'd18, 4'b1001); chk("reset", 32'h0, 1'b1);
    step(1'b0, 32'd12, 32'd18, 4'b1001); chk("reset_release_add", 32'd30, 1'b0);

    step(1'b0, 32'd18, 32'd12, 4'b0001); chk("sub", 32'd6, 1'b0);
    step(1'b0, 32'd0, 32'd1, 4'b0001);   chk("sub_wrap", 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b1001); chk("add_wrap", 32'h0, 1'b1);

    step(1'b0, 32'd18, 32'd12, 4'b0010); chk("xor", 32'd30, 1'b0);
    step(1'b0, 32'd18, 32'd12, 4'b0011); chk("or", 32'd30, 1'b0);
    step(1'b0, 32'd18, 32'd12, 4'b0100); chk("and", 32'd0, 1'b1);

    step(1'b0, 32'd18, 32'd2, 4'b0101); chk("sll", 32'd72, 1'b0);
    step(1'b0, 32'd18, 32'd2, 4'b1101); chk("srl", 32'd4, 1'b0);
    step(1'b0, 32'h8000_0000, 32'd4, 4'b1110); chk("sra", 32'hF800_0000, 1'b0);
    step(1'b0, 32'h8000_0000, 32'd4, 4'b1101); chk("srl_msb", 32'h0800_0000, 1'b0);
    step(1'b0, 32'd1, 32'd34, 4'b0101); chk("sll_mod32", 32'd4, 1'b0);
    step(1'b0, 32'hDEAD_BEEF, 32'd32, 4'b0101); chk("sll_zero_shift", 32'hDEAD_BEEF, 1'b0);

    step(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0110); chk("slt", 32'd1, 1'b0);
    step(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0111); chk("sltu", 32'd0, 1'b1);
    step(1'b0, 32'd18, 32'd2, 4'b1111); chk("reserved", 32'd0, 1'b1);

    step(1'b0, 32'd12, 32'd18, 4'b1001); chk("b2b_add", 32'd30, 1'b0);
    step(1'b0, 32'd18, 32'd12, 4'b0001); chk("b2b_sub", 32'd6, 1'b0);
    step(1'b0, 32'd18, 32'd12, 4'b0010); chk("b2b_xor", 32'd30, 1'b0);

    step(1'b0, 32'd7, 32'd6, 4'b1010);
`ifdef ALU_MUL_EN
    chk("mul", 32'd42, 1'b0);
`else
    chk("mul_reserved", 32'd0, 1'b1);
`endif

    step(1'b1, 32'd5, 32'd5, 4'b1001); chk("reset_midstream", 32'h0, 1'b1);

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 31) == 0), pick(), pick(), 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
